lc3_fetch_ctrl: RTL

//  Fetch-stage sequencer for the pipelined LC-3. Drives the load enables of the PC and IR

---
 rtl/lc3_pkg.sv | 14 +
 rtl/lc3_fetch_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: fetch sequencer states and architectural constants.
package lc3_pkg;

    localparam int          LC3_ADDR_W   = 16;
    localparam int          LC3_CNT_W    = 16;
    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_ctrl.sv
// Fetch-stage sequencer for the pipelined LC-3: drives PC/IR load enables, imem requests,
// decode back-pressure, redirects and HALT.
module lc3_fetch_ctrl
    import lc3_pkg::*;
#(
    parameter int                ADDR_W   = LC3_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_PC),
    parameter int                CNT_W    = LC3_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_ld,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ir_ld,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic              r_if_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [CNT_W-1:0]  r_fetch_cnt;

    logic              w_pc_ld;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_ir_ld;
    logic              w_imem_req;
    logic              w_xfer;
    logic              w_slot_free;
    logic              w_redirect_eff;
    logic              w_if_valid_next;

    assign w_slot_free    = !r_if_valid || !stall;
    // The BOOT PC load wins over any redirect arriving in the same cycle.
    assign w_redirect_eff = redirect && (r_state != FS_BOOT);

    // Next-state and per-cycle PC/IR/imem control.
    always_comb begin
        w_pc_ld      = 1'b0;
        w_pc_next    = pc_q;
        w_ir_ld      = 1'b0;
        w_imem_req   = 1'b0;
        w_xfer       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            FS_BOOT: begin
                w_pc_ld      = 1'b1;
                w_pc_next    = RESET_PC;
                w_state_next = FS_RUN;
            end
            FS_RUN: begin
                if (redirect) begin
                    w_pc_ld   = 1'b1;
                    w_pc_next = redirect_pc;
                end else if (halt) begin
                    w_state_next = FS_HALTED;
                end else begin
                    w_imem_req = w_slot_free;
                    if (w_slot_free && imem_ack) begin
                        w_xfer    = 1'b1;
                        w_ir_ld   = 1'b1;
                        w_pc_ld   = 1'b1;
                        w_pc_next = pc_q + PC_ONE;
                    end else begin
                        w_xfer = 1'b0;
                    end
                end
            end
            FS_HALTED: begin
                if (redirect) begin
                    w_pc_ld      = 1'b1;
                    w_pc_next    = redirect_pc;
                    w_state_next = FS_RUN;
                end else begin
                    w_state_next = FS_HALTED;
                end
            end
            default: begin
                w_state_next = FS_BOOT;
            end
        endcase
    end

    // IR valid flag: redirect flushes, a transfer fills, otherwise held only under stall.
    always_comb begin
        if (w_redirect_eff) begin
            w_if_valid_next = 1'b0;
        end else if (w_xfer) begin
            w_if_valid_next = 1'b1;
        end else if (stall) begin
            w_if_valid_next = r_if_valid;
        end else begin
            w_if_valid_next = 1'b0;
        end
    end

    // State, IR bookkeeping and retired-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FS_BOOT;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_if_valid <= w_if_valid_next;
            if (w_xfer) begin
                r_if_pc     <= pc_q;
                r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
            end
        end
    end

    // Load strobes are forced low while reset is held so a mid-fetch reset drops the transfer.
    assign pc_ld     = w_pc_ld && rst_n;
    assign ir_ld     = w_ir_ld && rst_n;
    assign imem_req  = w_imem_req && rst_n;
    assign pc_next   = w_pc_next;
    assign imem_addr = pc_q;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign fetch_cnt = r_fetch_cnt;

endmodule
